// File: rtl/seg_scan_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : seg_scan_pkg                                                 |
// | Purpose  : Shared types and constants for the seven-segment scanner.    |
// |            Holds the scan FSM state enum, the "all dark" drive values   |
// |            and a helper that builds a one-cold digit select.            |
// | Ports    : none (package)                                              |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
package seg_scan_pkg;

   typedef enum logic [1:0] {
      BLANK = 2'd0,   // anti-ghost gap at the start of every slot
      ON    = 2'd1,   // selected digit driven
      DIM   = 2'd2    // remainder of the slot dark, sets the duty cycle
   } scan_state_t;

   localparam logic [7:0] SEG_OFF  = 8'hFF;   // active-low: all segments off
   localparam logic [7:0] SEL_NONE = 8'hFF;   // active-low: no digit selected

   // One-cold select vector for digit position idx.
   function automatic logic [7:0] sel_for(input logic [2:0] idx);
      return ~(8'h01 << idx);
   endfunction

endpackage
`default_nettype wire

// File: rtl/scan_slot_timer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : scan_slot_timer                                              |
// | Purpose  : Slot counter (0..TICK_DIV-1) and digit index (0..7).         |
// |            The index advances whenever the slot counter wraps.         |
// | Ports    : clk, rst_n (async, active-low)                               |
// |            count       - position inside the current slot               |
// |            idx         - digit currently being scanned                  |
// |            slot_wrap   - count is at its last value this cycle          |
// |            frame_pulse - count 0 of digit 0 (first cycle of a frame)     |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module scan_slot_timer #(
   parameter int TICK_DIV = 64
) (
   input  logic                        clk,
   input  logic                        rst_n,
   output logic [$clog2(TICK_DIV)-1:0] count,
   output logic [2:0]                  idx,
   output logic                        slot_wrap,
   output logic                        frame_pulse
);

   localparam int CW = $clog2(TICK_DIV);

   assign slot_wrap   = (count == CW'(TICK_DIV - 1));
   assign frame_pulse = (count == '0) && (idx == 3'd0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
         idx   <= 3'd0;
      end else if (slot_wrap) begin
         count <= '0;
         idx   <= idx + 3'd1;   // 7 wraps naturally to 0
      end else begin
         count <= count + CW'(1);
      end
   end

endmodule
`default_nettype wire

// File: rtl/seven_seg_scan_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : seven_seg_scan_ctrl                                          |
// | Purpose  : Time-multiplexed driver for an 8-digit seven-segment display |
// |            with anti-ghost blanking and optional brightness control.   |
// | Config   : SEG_SCAN_DIM_EN - when defined, brightness (0..7) shortens   |
// |            the ON window and the rest of each slot is spent in DIM.    |
// |            When undefined, brightness is ignored and ON fills the slot. |
// | Ports    : clk, rst_n (async, active-low)                               |
// |            digits[63:0]  - digit k pattern at [8k+7:8k], 1 = lit        |
// |            digit_en[7:0] - 0 keeps that digit dark for its slot         |
// |            brightness    - duty level 0..7                              |
// |            seg[7:0]      - active-low segment drive (registered)        |
// |            seg_sel[7:0]  - active-low one-cold digit select (registered)|
// |            frame_start   - one-cycle pulse at the start of digit 0 slot |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module seven_seg_scan_ctrl
   import seg_scan_pkg::*;
#(
   parameter int TICK_DIV  = 64,
   parameter int BLANK_CYC = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [63:0] digits,
   input  logic [7:0]  digit_en,
   input  logic [2:0]  brightness,
   output logic [7:0]  seg,
   output logic [7:0]  seg_sel,
   output logic        frame_start
);

   localparam int CW = $clog2(TICK_DIV);

   logic [CW-1:0] count;
   logic [2:0]    idx;
   logic          slot_wrap;
   logic          frame_pulse;

   scan_state_t   state;
   scan_state_t   state_nx;
   logic [63:0]   sh_digits;
   logic [7:0]    sh_en;
   logic [CW:0]   on_end;     // one extra bit so on_end can equal TICK_DIV
   logic [CW:0]   count_p1;
   logic [7:0]    seg_nx;
   logic [7:0]    sel_nx;

   scan_slot_timer #(
      .TICK_DIV (TICK_DIV)
   ) u_timer (
      .clk         (clk),
      .rst_n       (rst_n),
      .count       (count),
      .idx         (idx),
      .slot_wrap   (slot_wrap),
      .frame_pulse (frame_pulse)
   );

`ifdef SEG_SCAN_DIM_EN
   localparam logic [CW+3:0] SPAN = (CW+4)'(TICK_DIV - BLANK_CYC);

   logic [2:0]    bright_q;
   logic [CW+3:0] span_prod;   // wide enough for SPAN * 8
   logic          unused_prod_lsb;

   // Brightness is latched once per slot so a change never splits a slot.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bright_q <= 3'd0;
      end else if (count == '0) begin
         bright_q <= brightness;
      end
   end

   always_comb begin
      span_prod = SPAN * ({{(CW+1){1'b0}}, bright_q} + (CW+4)'(1));
      on_end    = (CW+1)'(BLANK_CYC) + span_prod[CW+3:3];
   end

   assign unused_prod_lsb = ^span_prod[2:0];
`else
   logic unused_brightness;

   assign on_end            = (CW+1)'(TICK_DIV);
   assign unused_brightness = ^brightness;
`endif

   assign count_p1 = {1'b0, count} + (CW+1)'(1);

   // Next-state logic looks one count ahead so state stays aligned with
   // count: state is BLANK at count 0, ON from BLANK_CYC, DIM from on_end.
   always_comb begin
      state_nx = state;
      if (slot_wrap) begin
         state_nx = BLANK;
      end else begin
         case (state)
            BLANK:   if (count == CW'(BLANK_CYC - 1)) state_nx = ON;
            ON:      if (count_p1 == on_end)          state_nx = DIM;
            DIM:     state_nx = DIM;
            default: state_nx = BLANK;
         endcase
      end
   end

   always_comb begin
      seg_nx = SEG_OFF;
      sel_nx = SEL_NONE;
      if ((state == ON) && sh_en[idx]) begin
         sel_nx = sel_for(idx);
         seg_nx = ~sh_digits[{idx, 3'b000} +: 8];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= BLANK;
         sh_digits   <= '0;
         sh_en       <= '0;
         seg         <= SEG_OFF;
         seg_sel     <= SEL_NONE;
         frame_start <= 1'b0;
      end else begin
         state       <= state_nx;
         seg         <= seg_nx;
         seg_sel     <= sel_nx;
         frame_start <= frame_pulse;
         // Shadows load on the same edge that raises frame_start, so a
         // whole frame always shows one consistent snapshot.
         if (frame_pulse) begin
            sh_digits <= digits;
            sh_en     <= digit_en;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_scan_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tb_seven_seg_scan_ctrl                                       |
// | Purpose  : Self-checking bench for seven_seg_scan_ctrl                  |
// |            (TICK_DIV=64, BLANK_CYC=8). Per-slot expectations are queued |
// |            when stimulus is applied and popped as each slot is observed.|
// | Config   : honours SEG_SCAN_DIM_EN for the expected ON-window length.   |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module tb_seven_seg_scan_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [63:0] digits;
   logic [7:0]  digit_en;
   logic [2:0]  brightness;
   logic [7:0]  seg;
   logic [7:0]  seg_sel;
   logic        frame_start;

   int vectors     = 0;
   int miscompares = 0;

   typedef struct {
      logic [7:0] sel;
      logic [7:0] seg;
      int         on_cyc;
   } slot_exp_t;

   slot_exp_t sb[$];

   always #5 clk = ~clk;

   seven_seg_scan_ctrl #(
      .TICK_DIV  (64),
      .BLANK_CYC (8)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .digits      (digits),
      .digit_en    (digit_en),
      .brightness  (brightness),
      .seg         (seg),
      .seg_sel     (seg_sel),
      .frame_start (frame_start)
   );

   function automatic int exp_on(input logic [2:0] b);
`ifdef SEG_SCAN_DIM_EN
      return ((64 - 8) * (int'(b) + 1)) / 8;
`else
      return 56;
`endif
   endfunction

   function automatic void push_frame(input logic [63:0] d, input logic [7:0] en,
                                      input logic [2:0] b);
      slot_exp_t  e;
      logic [7:0] one;
      for (int k = 0; k < 8; k++) begin
         one = 8'h01;
         if (en[k]) begin
            e.sel    = ~(one << k);
            e.seg    = ~d[8*k +: 8];
            e.on_cyc = exp_on(b);
         end else begin
            e.sel    = 8'hFF;
            e.seg    = 8'hFF;
            e.on_cyc = 0;
         end
         sb.push_back(e);
      end
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Waits for frame_start; exp_lat > 0 also checks how many cycles it took.
   task automatic wait_fs(input int exp_lat);
      int n     = 0;
      bit found = 1'b0;
      while (!found && n < 1200) begin
         @(negedge clk);
         n++;
         if (frame_start === 1'b1) found = 1'b1;
      end
      if (exp_lat > 0) check("frame_start_latency", n, exp_lat);
      else             check("frame_start_found", 32'(found), 1);
   endtask

   // Starts on the frame_start cycle; observes 8 slot windows of 64 cycles.
   task automatic check_frame(input bit chg, input logic [63:0] new_d);
      slot_exp_t  e;
      int         low;
      int         fs_cnt = 0;
      logic       fs_last = 1'b0;
      logic [7:0] osel;
      logic [7:0] oseg;
      bit         bad;
      for (int k = 0; k < 8; k++) begin
         e    = sb.pop_front();
         low  = 0;
         osel = 8'hFF;
         oseg = 8'hFF;
         bad  = 1'b0;
         for (int c = 1; c <= 64; c++) begin
            @(negedge clk);
            if (chg && (k*64 + c == 100)) digits = new_d;
            fs_cnt += int'(frame_start);
            fs_last = frame_start;
            if (seg_sel !== 8'hFF) begin
               if (low == 0) begin
                  osel = seg_sel;
                  oseg = seg;
               end else if (seg_sel !== osel || seg !== oseg) begin
                  bad = 1'b1;
               end
               low++;
            end else if (seg !== 8'hFF) begin
               bad = 1'b1;
            end
         end
         if (bad) osel = 8'h00;
         check($sformatf("slot%0d_on_cycles", k), low, e.on_cyc);
         check($sformatf("slot%0d_seg_sel", k), {24'd0, osel}, {24'd0, e.sel});
         check($sformatf("slot%0d_seg", k), {24'd0, oseg}, {24'd0, e.seg});
      end
      check("frame_start_count", fs_cnt, 1);
      check("frame_start_period", {31'd0, fs_last}, 1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [63:0] d0;
      logic [63:0] d1;
      d0 = 64'h0123456789ABCDEF;
      d1 = 64'hFEDCBA9876543210;

      rst_n      = 1'b0;
      digits     = d0;
      digit_en   = 8'hFF;
      brightness = 3'd7;
      repeat (3) @(negedge clk);
      check("reset_seg", {24'd0, seg}, 32'hFF);
      check("reset_seg_sel", {24'd0, seg_sel}, 32'hFF);
      check("reset_frame_start", {31'd0, frame_start}, 0);

      // Full brightness, all digits enabled.
      rst_n = 1'b1;
      wait_fs(1);
      push_frame(d0, 8'hFF, 3'd7);
      check_frame(1'b0, 64'd0);

      // Brightness 3, then 0 (each takes effect a full frame later).
      brightness = 3'd3;
      repeat (512) @(negedge clk);
      push_frame(d0, 8'hFF, 3'd3);
      check_frame(1'b0, 64'd0);

      brightness = 3'd0;
      repeat (512) @(negedge clk);
      push_frame(d0, 8'hFF, 3'd0);
      check_frame(1'b0, 64'd0);

      // Digits 1 and 3 disabled.
      brightness = 3'd7;
      digit_en   = 8'b1111_0101;
      repeat (512) @(negedge clk);
      push_frame(d0, 8'b1111_0101, 3'd7);
      check_frame(1'b0, 64'd0);

      // Digits changed at cycle 100: old frame completes, new one follows.
      digit_en = 8'hFF;
      repeat (512) @(negedge clk);
      push_frame(d0, 8'hFF, 3'd7);
      push_frame(d1, 8'hFF, 3'd7);
      check_frame(1'b1, d1);
      check_frame(1'b0, 64'd0);

      // Reset pulse during the ON window of digit 5.
      repeat (5*64 + 20) @(negedge clk);
      check("digit5_sel_before_reset", {24'd0, seg_sel}, 32'hDF);
      check("digit5_seg_before_reset", {24'd0, seg}, {24'd0, ~d1[47:40]});
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset_seg", {24'd0, seg}, 32'hFF);
      check("async_reset_seg_sel", {24'd0, seg_sel}, 32'hFF);
      check("async_reset_frame_start", {31'd0, frame_start}, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      wait_fs(1);
      push_frame(d1, 8'hFF, 3'd7);
      check_frame(1'b0, 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/seven_seg_scan_ctrl.md
SEVEN_SEG_SCAN_CTRL -- requirements
Module: seven_seg_scan_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 64, clocks per digit slot; power of two, at least 64.
REQ-002 SHALL have parameter BLANK_CYC, default 8, anti-ghost blank cycles at the start of each slot; less than TICK_DIV/2.
REQ-003 SHALL have port clk, input, 1, single system clock, rising edge.
REQ-004 SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-005 SHALL have port digits, input, 64, segment patterns; digit k at bits [8k+7:8k], segment bit 1 = lit.
REQ-006 SHALL have port digit_en, input, 8, per-digit enable; 0 = digit stays dark for its slot.
REQ-007 SHALL have port brightness, input, 3, duty level 0..7.
REQ-008 SHALL have port seg, output, 8, active-low segment drive.
REQ-009 SHALL have port seg_sel, output, 8, active-low digit select, one-cold or all-ones.
REQ-010 SHALL have port frame_start, output, 1, one-cycle pulse at the start of the slot for digit 0.

Function
REQ-011 SHALL scan digits 0..7 in ascending order, one slot each, wrapping from 7 to 0; frame = 8*TICK_DIV cycles.
REQ-012 SHALL use a slot counter 0..TICK_DIV-1 that wraps to 0 and advances the digit index on wrap.
REQ-013 SHALL snapshot digits and digit_en into shadow registers on the cycle frame_start is asserted; mid-frame input changes SHALL NOT take effect until the next frame.
REQ-014 SHALL implement FSM states BLANK, ON, DIM; each slot enters BLANK at count 0.
REQ-015 BLANK -> ON at count BLANK_CYC; ON -> DIM at count on_end; DIM -> BLANK at slot wrap.
REQ-016 on_end SHALL equal BLANK_CYC + (((TICK_DIV-BLANK_CYC)*(brightness+1))>>3), computed without overflow; when on_end = TICK_DIV, DIM is skipped.
REQ-017 brightness SHALL be sampled once per slot at count 0.
REQ-018 In BLANK and DIM, seg and seg_sel SHALL both be all-ones.
REQ-019 In ON with the shadow enable for the digit set, seg_sel[idx] SHALL be 0, the other select bits 1, and seg = ~shadow pattern.
REQ-020 In ON with the shadow enable clear, outputs SHALL remain all-ones, while slot timing is unchanged.
REQ-021 seg, seg_sel and frame_start SHALL be registered outputs, with one cycle of latency from the state/count they reflect.

Reset
REQ-022 SHALL, while rst_n = 0, hold seg = 8'hFF, seg_sel = 8'hFF, frame_start = 0, state BLANK, count 0, idx 0, shadows 0.
REQ-023 SHALL, on rst_n deassertion mid-slot, start a fresh frame: the first frame_start occurs on the first clock after release.

Configuration
REQ-024 SHALL, when SEG_SCAN_DIM_EN is defined, implement brightness-controlled DIM per REQ-016/017.
REQ-025 SHALL, when SEG_SCAN_DIM_EN is undefined, ignore brightness, fix on_end = TICK_DIV, and never enter DIM.

Structure
REQ-026 SHALL place the FSM state enum and the constants SEG_OFF = 8'hFF and SEL_NONE = 8'hFF in package seg_scan_pkg.
REQ-027 SHALL place the slot counter and digit index in sub-module scan_slot_timer, with outputs count, idx, slot_wrap and frame_pulse.

Verification (TICK_DIV=64, BLANK_CYC=8)
REQ-028 Reset release, all digit_en = 1, brightness = 7: seg_sel low for 56 of every 64 cycles; frame_start period 512.
REQ-029 brightness = 3: seg_sel low for 28 cycles per slot; brightness = 0: 7 cycles; without SEG_SCAN_DIM_EN, 56 cycles for every value.
REQ-030 digits = 64'h0123456789ABCDEF: digit 0 is driven with seg = 8'h10; digit 7 with seg = 8'hFE; the select sequence runs FE, FD, ..., 7F, then wraps to FE.
REQ-031 digit_en = 8'b1111_0101: slots 1 and 3 stay all-ones while the slot timing is unchanged.
REQ-032 digits changed at cycle 100 of a frame: the old value is displayed until the next frame_start, and the new value after it.
REQ-033 rst_n pulsed low during the ON state of digit 5: outputs are all-ones asynchronously; after release, the scan restarts at digit 0 with frame_start.
